sort4_stream: RTL and testbench



---
 rtl/sort_pkg.sv | 44 ++++
 rtl/sort4_stream_cmp_swap.sv | 22 ++
 rtl/sort4_stream.sv | 136 +++++++++++++
 tb/tb_sort4_stream.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the serial 4-word sorter: state encoding, group sizes,
// and the fixed compare-exchange schedule (step -> register index pair).
// Pure declarations; no latency and no flow control of its own.
package sort_pkg;

    localparam int NUM_WORDS  = 4;
    localparam int SORT_STEPS = 5;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // Lower-index register of the pair compared at a given step.
    // The order (0,1)(2,3)(0,2)(1,3)(1,2) is the optimal 4-input network.
    function automatic logic [1:0] step_lo(input logic [2:0] step);
        logic [1:0] lo;
        case (step)
            3'd0:    lo = 2'd0;
            3'd1:    lo = 2'd2;
            3'd2:    lo = 2'd0;
            3'd3:    lo = 2'd1;
            3'd4:    lo = 2'd1;
            default: lo = 2'd0;
        endcase
        return lo;
    endfunction

    // Higher-index register of the pair compared at a given step.
    function automatic logic [1:0] step_hi(input logic [2:0] step);
        logic [1:0] hi;
        case (step)
            3'd0:    hi = 2'd1;
            3'd1:    hi = 2'd3;
            3'd2:    hi = 2'd2;
            3'd3:    hi = 2'd3;
            3'd4:    hi = 2'd2;
            default: hi = 2'd1;
        endcase
        return hi;
    endfunction

endpackage

// File: rtl/sort4_stream_cmp_swap.sv
// Combinational compare-exchange of two words; lo_out goes to the lower-index slot.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; operands are muxed in by the parent each cycle.
// Ports: a_i/b_i = lower/higher-index operands, lo_out_o/hi_out_o = ordered results.
module cmp_swap #(
    parameter int WIDTH  = 8,
    parameter bit ASCEND = 1'b1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] lo_out_o,
    output logic [WIDTH-1:0] hi_out_o
);

    logic swap;

    // Strict compares so equal words never move (keeps load order for ties).
    assign swap     = ASCEND ? (a_i > b_i) : (a_i < b_i);
    assign lo_out_o = swap ? b_i : a_i;
    assign hi_out_o = swap ? a_i : b_i;

endmodule

// File: rtl/sort4_stream.sv
// Serial 4-word sorter: load 4 words, 5-step compare-exchange, stream out sorted.
// Latency: first out_valid 6 cycles after the edge accepting the 4th word.
// Backpressure: in_ready low outside LOAD; output word held while out_ready is low.
// Ports: clk/reset_n; in_valid/in_ready/in_data producer side;
//        out_valid/out_ready/out_data/out_last consumer side; busy = SORT or OUT.
module sort4_stream
    import sort_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit ASCEND = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [2:0]       step_q, step_d;
    logic [WIDTH-1:0] r_q [NUM_WORDS];
    logic [WIDTH-1:0] r_d [NUM_WORDS];
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic [1:0]       lo_idx, hi_idx;
    logic [WIDTH-1:0] cmp_lo, cmp_hi;

    assign lo_idx = step_lo(step_q);
    assign hi_idx = step_hi(step_q);

    // Single shared comparator; its operands follow the step schedule.
    cmp_swap #(
        .WIDTH  (WIDTH),
        .ASCEND (ASCEND)
    ) u_cmp_swap (
        .a_i      (r_q[lo_idx]),
        .b_i      (r_q[hi_idx]),
        .lo_out_o (cmp_lo),
        .hi_out_o (cmp_hi)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        step_d      = step_q;
        r_d         = r_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    r_d[idx_q] = in_data;
                    idx_d      = idx_q + 2'd1;
                    if (idx_q == 2'(NUM_WORDS - 1)) begin
                        idx_d   = 2'd0;
                        step_d  = 3'd0;
                        state_d = ST_SORT;
                    end
                end
            end
            ST_SORT: begin
                r_d[lo_idx] = cmp_lo;
                r_d[hi_idx] = cmp_hi;
                if (step_q == 3'(SORT_STEPS - 1)) begin
                    step_d  = 3'd0;
                    idx_d   = 2'd0;
                    state_d = ST_OUT;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_OUT: begin
                // First OUT cycle registers word 0; afterwards the next word is
                // fetched only on a handshake, so a stalled word never changes.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = r_q[0];
                    out_last_d  = 1'b0;
                end else if (out_ready) begin
                    if (idx_q == 2'(NUM_WORDS - 1)) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        idx_d       = 2'd0;
                        state_d     = ST_LOAD;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        out_data_d = r_q[idx_q + 2'd1];
                        out_last_d = (idx_q == 2'(NUM_WORDS - 2));
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LOAD;
            idx_q       <= 2'd0;
            step_q      <= 3'd0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            step_q      <= step_d;
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_LOAD);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_sort4_stream.sv
// Self-checking bench for sort4_stream: directed groups plus random groups
// checked against a plain insertion-sort reference model.
// Two instances (ascending and descending) share clock and reset.
module tb_sort4_stream;

    typedef logic [7:0] grp_t [4];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       reset_n;
    logic       in_valid, out_ready;
    logic [7:0] in_data;
    bit         sel;  // 0 = ascending instance, 1 = descending instance

    logic       a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [7:0] a_out_data;
    logic       d_in_ready, d_out_valid, d_out_last, d_busy;
    logic [7:0] d_out_data;

    sort4_stream #(.WIDTH(8), .ASCEND(1'b1)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid & ~sel),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready & ~sel),
        .out_data  (a_out_data),
        .out_last  (a_out_last),
        .busy      (a_busy)
    );

    sort4_stream #(.WIDTH(8), .ASCEND(1'b0)) dut_d (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid & sel),
        .in_ready  (d_in_ready),
        .in_data   (in_data),
        .out_valid (d_out_valid),
        .out_ready (out_ready & sel),
        .out_data  (d_out_data),
        .out_last  (d_out_last),
        .busy      (d_busy)
    );

    logic       in_ready_o, out_valid_o, out_last_o, busy_o;
    logic [7:0] out_data_o;
    assign in_ready_o  = sel ? d_in_ready  : a_in_ready;
    assign out_valid_o = sel ? d_out_valid : a_out_valid;
    assign out_last_o  = sel ? d_out_last  : a_out_last;
    assign busy_o      = sel ? d_busy      : a_busy;
    assign out_data_o  = sel ? d_out_data  : a_out_data;

    int checks   = 0;
    int failures = 0;

    // Reference: insertion sort, reversed for descending order.
    task automatic ref_sort(input grp_t v, input bit desc, output grp_t s);
        logic [7:0] t;
        s = v;
        for (int i = 1; i < 4; i++) begin
            for (int j = i; j > 0; j--) begin
                if (desc ? (s[j] > s[j-1]) : (s[j] < s[j-1])) begin
                    t = s[j]; s[j] = s[j-1]; s[j-1] = t;
                end
            end
        end
    endtask

    function automatic logic [31:0] pack(input grp_t g);
        return {g[0], g[1], g[2], g[3]};
    endfunction

    // Loads one group and collects four output words. All timing is at negedge.
    // mode: 0 = out_ready always 1, 1 = toggle, 2 = random.
    task automatic run_group(input grp_t v, input int mode, input int gaps, input bit hold255,
                             output grp_t got, output logic [3:0] lasts, output int lat,
                             output int stall_bad, output int rdy_bad, output bit tout);
        int  w, n, acc;
        bit  stalled, seen;
        logic [7:0] held;
        for (int i = 0; i < 4; i++) begin
            if (gaps > 0) repeat ($urandom_range(0, gaps)) @(negedge clk);
            w = 0;
            while (!in_ready_o && w < 50) begin @(negedge clk); w++; end
            in_valid = 1'b1;
            in_data  = v[i];
            @(negedge clk);
            in_valid = 1'b0;
        end
        acc = cyc;
        if (hold255) begin in_valid = 1'b1; in_data = 8'hFF; end
        n = 0; stalled = 0; seen = 0; held = 8'h00;
        lat = -1; stall_bad = 0; rdy_bad = 0; tout = 1'b1; lasts = 4'b0;
        got = '{default: 8'h00};
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready_o) rdy_bad++;
            if (out_valid_o && !seen) begin seen = 1; lat = cyc - acc; end
            if (stalled && (!out_valid_o || out_data_o !== held)) stall_bad++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = k[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid_o && out_ready) begin
                got[n]   = out_data_o;
                lasts[n] = out_last_o;
                n++;
                stalled = 0;
            end else begin
                stalled = out_valid_o;
                held    = out_data_o;
            end
            if (n == 4) begin tout = 1'b0; break; end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({in_ready_o, out_valid_o, out_last_o, busy_o, out_data_o} !== {4'b1000, 8'h00}) begin
            failures++;
            $display("FAIL reset_state got rdy/vld/last/busy/data=%b%b%b%b/%h want 1000/00",
                     in_ready_o, out_valid_o, out_last_o, busy_o, out_data_o);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready_o, out_valid_o, busy_o} !== 3'b100) begin
            failures++;
            $display("FAIL post_reset_idle got rdy/vld/busy=%b%b%b want 100", in_ready_o, out_valid_o, busy_o);
        end
    endtask

    task automatic test_basic_ascend();
        grp_t v, got; logic [3:0] lasts; int lat, sb, rb; bit tout;
        sel = 0;
        v = '{8'd200, 8'd17, 8'd99, 8'd5};
        run_group(v, 0, 0, 0, got, lasts, lat, sb, rb, tout);
        checks++;
        if (pack(got) !== {8'd5, 8'd17, 8'd99, 8'd200} || tout) begin
            failures++;
            $display("FAIL basic_order got %h want 051163c8 (timeout=%0d)", pack(got), tout);
        end
        checks++;
        if (lasts !== 4'b1000) begin
            failures++;
            $display("FAIL basic_last got %b want 1000", lasts);
        end
        checks++;
        if (lat !== 6) begin
            failures++;
            $display("FAIL basic_latency got %0d want 6", lat);
        end
        checks++;
        if (sb !== 0) begin
            failures++;
            $display("FAIL basic_consecutive got %0d gaps want 0", sb);
        end
    endtask

    task automatic test_descend();
        grp_t v, got; logic [3:0] lasts; int lat, sb, rb; bit tout;
        sel = 1;
        v = '{8'd3, 8'd250, 8'd0, 8'd128};
        run_group(v, 0, 0, 0, got, lasts, lat, sb, rb, tout);
        checks++;
        if (pack(got) !== {8'd250, 8'd128, 8'd3, 8'd0} || tout) begin
            failures++;
            $display("FAIL descend_order got %h want fa800300 (timeout=%0d)", pack(got), tout);
        end
        checks++;
        if (lasts !== 4'b1000 || lat !== 6) begin
            failures++;
            $display("FAIL descend_last_lat got last=%b lat=%0d want 1000/6", lasts, lat);
        end
        sel = 0;
    endtask

    task automatic test_all_equal();
        grp_t v, got; logic [3:0] lasts; int lat, sb, rb; bit tout;
        v = '{8'd7, 8'd7, 8'd7, 8'd7};
        run_group(v, 0, 0, 0, got, lasts, lat, sb, rb, tout);
        checks++;
        if (pack(got) !== 32'h07070707 || tout || lasts !== 4'b1000) begin
            failures++;
            $display("FAIL all_equal got %h last=%b want 07070707/1000", pack(got), lasts);
        end
    endtask

    task automatic test_stall_and_ignore();
        grp_t v, got; logic [3:0] lasts; int lat, sb, rb; bit tout;
        v = '{8'd1, 8'd2, 8'd3, 8'd4};
        run_group(v, 1, 0, 1, got, lasts, lat, sb, rb, tout);
        checks++;
        if (pack(got) !== 32'h01020304 || tout) begin
            failures++;
            $display("FAIL stall_order got %h want 01020304 (timeout=%0d)", pack(got), tout);
        end
        checks++;
        if (sb !== 0) begin
            failures++;
            $display("FAIL stall_hold got %0d unstable cycles want 0", sb);
        end
        checks++;
        if (rb !== 0) begin
            failures++;
            $display("FAIL busy_in_ready got %0d cycles with in_ready=1 want 0", rb);
        end
        // A follow-up group must not contain the ignored 255.
        v = '{8'd9, 8'd8, 8'd6, 8'd7};
        run_group(v, 0, 0, 0, got, lasts, lat, sb, rb, tout);
        checks++;
        if (pack(got) !== 32'h06070809 || tout) begin
            failures++;
            $display("FAIL after_ignore got %h want 06070809", pack(got));
        end
    endtask

    task automatic test_reset_mid_load();
        grp_t v, got; logic [3:0] lasts; int lat, sb, rb; bit tout;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'd10; @(negedge clk);
        in_data = 8'd20;                 @(negedge clk);
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({in_ready_o, out_valid_o, out_last_o, busy_o, out_data_o} !== {4'b1000, 8'h00}) begin
            failures++;
            $display("FAIL midload_reset got rdy/vld/last/busy/data=%b%b%b%b/%h want 1000/00",
                     in_ready_o, out_valid_o, out_last_o, busy_o, out_data_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        v = '{8'd40, 8'd30, 8'd20, 8'd10};
        run_group(v, 0, 0, 0, got, lasts, lat, sb, rb, tout);
        checks++;
        if (pack(got) !== 32'h0a141e28 || tout || lasts !== 4'b1000) begin
            failures++;
            $display("FAIL midload_group got %h last=%b want 0a141e28/1000", pack(got), lasts);
        end
    endtask

    task automatic test_random();
        grp_t v, got, exp; logic [3:0] lasts; int lat, sb, rb; bit tout;
        for (int g = 0; g < 60; g++) begin
            sel = (g >= 50);
            for (int i = 0; i < 4; i++) v[i] = 8'($urandom_range(0, 255));
            ref_sort(v, sel, exp);
            run_group(v, 2, 2, 0, got, lasts, lat, sb, rb, tout);
            checks++;
            if (pack(got) !== pack(exp) || tout) begin
                failures++;
                $display("FAIL random_group g=%0d in=%h got %h want %h", g, pack(v), pack(got), pack(exp));
            end
            checks++;
            if (lasts !== 4'b1000 || sb !== 0) begin
                failures++;
                $display("FAIL random_last_hold g=%0d got last=%b unstable=%0d want 1000/0", g, lasts, sb);
            end
        end
        sel = 0;
    endtask

    initial begin
        sel       = 0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        reset_n   = 1'b1;
        #2 reset_n = 1'b0;
        test_reset();
        test_basic_ascend();
        test_descend();
        test_all_equal();
        test_stall_and_ignore();
        test_reset_mid_load();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
